wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Parametrised N-master to 1-slave Wishbone B4 round-robin arbiter with a per-transaction watchdog. It is the next-generation shared-slave front end for the SoC fabric, placed between the bus-master blocks (daq, dsp, cpu and future masters) and a single slave port such as a wb_ram bank. Compared with fixed-priority sharing, it adds:

- fair rotation between masters;
- cycle-locked ownership, so bursts are never split;
- a timeout that converts a hung slave into a Wishbone error.

## Interface
Parameters:
- NUM_MASTERS, 3, number of master ports (2..16)
- DW, 32, data width (multiple of 8)
- AW, 32, address width
- TIMEOUT, 255, watchdog limit in cycles of stalled strobe; 0 disables the watchdog

Ports (master buses flattened, master k occupies slice k):
- wb_clk  in  1  bus clock; all logic on rising edge
- wb_rst_n  in  1  reset, asynchronous assert, active-low
- m_adr_i  in  NUM_MASTERS*AW  master addresses
- m_dat_i  in  NUM_MASTERS*DW  master write data
- m_sel_i  in  NUM_MASTERS*DW/8  byte selects
- m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS each  write enable, cycle, strobe
- m_cti_i  in  NUM_MASTERS*3  cycle type
- m_bte_i  in  NUM_MASTERS*2  burst type
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  per-master terminations
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  slave-side copies of the selected master
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  slave responses
- grant_o  out  NUM_MASTERS  one-hot current owner; all zeros when idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

## Operation
- FSM states: IDLE and OWNED.
- **IDLE**
  - If any m_cyc_i is high, select the first requester scanning upward from last_grant+1, wrapping modulo NUM_MASTERS.
  - Register the one-hot grant and go to OWNED.
  - With no requester, stay in IDLE with grant = 0.
- **OWNED**
  - Slave outputs are a combinational mux of the granted master's signals. s_cyc_o and s_stb_o are gated by the grant.
  - Only the granted master receives s_ack_i, s_err_i and s_rty_i. All other masters' terminations are 0.
  - Ownership is held for as long as the granted master holds m_cyc_i. This holds across stb gaps and across CTI 010 incrementing bursts.
  - When the granted m_cyc_i is low: set last_grant to the owner, clear grant and return to IDLE. There is exactly one dead cycle between owners.
- **Watchdog** (TIMEOUT ≠ 0)
  - A counter increments each OWNED cycle in which s_stb_o=1 and s_ack_i, s_err_i and s_rty_i are all 0.
  - The counter clears on any termination, on leaving OWNED, or when it fires.
  - When the count equals TIMEOUT, the arbiter does three things in that cycle:
    - asserts m_err_o of the owner for one cycle;
    - forces s_stb_o and s_cyc_o to 0;
    - pulses timeout_o.
  - Ownership is kept; the master decides whether to drop cyc.
  - Counter width is clog2(TIMEOUT+1).
- Reset values:
  - grant_o=0, state IDLE, last_grant=NUM_MASTERS-1 (master 0 wins first), counter 0, timeout_o=0.
  - Consequently all s_* strobes, m_ack_o, m_err_o and m_rty_o are 0, and m_dat_o equals s_dat_i.

## Timing
- Arbitration latency: requester cyc high at edge n gives grant_o and s_cyc_o high after edge n+1 with no competitors.
- Response path is combinational: s_ack_i reaches m_ack_o in the same cycle. The arbiter adds no wait states inside an owned cycle.
- Boundary cases:
  - Owner drops cyc while others request: IDLE for one cycle, then the next master in rotation is granted.
  - Owner drops cyc and re-requests in the IDLE cycle: it has the lowest priority among current requesters.
  - Single requester: it is granted repeatedly, with one dead cycle between cycles.
  - Watchdog fire in the same cycle as a slave termination: the termination wins, err is not injected, and the counter clears.
  - wb_rst_n low mid-transfer: grant clears asynchronously, so s_cyc_o and s_stb_o drop immediately; the slave must tolerate an abandoned cycle.
  - Requester's m_cyc_i deasserts before grant: no grant is issued to it.

## Structure
- Shared package/header wb_arb_defines.vh:
  - CTI codes (CLASSIC 000, CONST 001, INCR 010, EOB 111)
  - BTE codes
  - FSM state encodings IDLE/OWNED
- Sub-module rr_priority_select (combinational):
  - inputs: request vector and last_grant index
  - outputs: one-hot winner and its index
  - parametrised by NUM_MASTERS
- Top holds the FSM, grant register, muxes and watchdog counter.

## Test plan
- NUM_MASTERS=3; masters 0,1,2 assert cyc simultaneously, each doing 4 classic writes (slave acks after 1 cycle) → grants in order 0,1,2 with one idle cycle between; RAM contents match.
- Master 1 performs an 8-beat CTI 010 burst while master 0 requests → master 0 is not granted until master 1 drops cyc after the EOB beat.
- Slave never acks, TIMEOUT=16 → exactly 16 stalled cycles after stb, then m_err_o[owner]=1 for one cycle, timeout_o pulses, and s_stb_o=0 in that cycle.
- Slave acks on the same cycle the count reaches TIMEOUT → m_ack_o only; no err, no timeout_o.
- wb_rst_n pulled low mid-burst of master 2 → grant_o=0 and s_cyc_o=0 asynchronously; after release, a new request from master 0 wins.
- NUM_MASTERS=5 with only master 4 requesting after reset → granted after one cycle; read data 0xDEADBEEF from the slave appears on m_dat_o with m_ack_o[4]=1.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: cycle/burst type
// codes, FSM state encoding and an index-width helper.
package wb_rr_arbiter_pkg;

    // Cycle type identifiers (CTI)
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type extensions (BTE)
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // Width of an index into n masters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_priority_select.sv
// Round-robin winner selection: the first requester above last_i wins,
// otherwise the lowest requester at or below last_i (wrap-around).
module rr_priority_select
    import wb_rr_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS = 3,
    localparam int IW          = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IW-1:0]          last_i,
    output logic [NUM_MASTERS-1:0] win_o,
    output logic [IW-1:0]          win_idx_o
);

    logic          hi_found;
    logic          lo_found;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Descending scan so the lowest qualifying index in each half is kept.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                if (IW'(k) > last_i) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IW'(k);
                end
            end
        end
        win_idx_o = hi_found ? hi_idx : lo_idx;
        win_o     = '0;
        if (hi_found || lo_found) begin
            win_o = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx_o;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone round-robin arbiter with cycle-locked
// ownership and a stalled-strobe watchdog that terminates hung cycles
// with an error to the owner.
//
//   state    | meaning
//   ST_IDLE  | no owner; arbitrate among m_cyc_i, grant on next edge
//   ST_OWNED | grant_q owner drives the slave until it drops m_cyc_i
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk,
    input  logic                        wb_rst_n,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);

    localparam int IW = idx_width(NUM_MASTERS);
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] win;
    logic [IW-1:0]          win_idx;

    logic                   owned;
    logic                   term;
    logic                   wd_window;
    logic                   fire;
    logic                   sel_cyc;
    logic                   sel_stb;

    rr_priority_select #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_sel (
        .req_i     (m_cyc_i),
        .last_i    (last_q),
        .win_o     (win),
        .win_idx_o (win_idx)
    );

    assign owned = (state_q == ST_OWNED);
    assign term  = s_ack_i | s_err_i | s_rty_i;

    // The watchdog window only depends on the count, so s_stb_o never
    // depends combinationally on the slave's own response; a termination
    // in the window still wins over the injected error.
    assign wd_window = WD_EN && owned && (cnt_q == CW'(TIMEOUT));
    assign fire      = wd_window && !term;

    // Request/data mux from the owning master onto the slave port.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (gidx_q == IW'(k)) begin
                sel_cyc = m_cyc_i[k];
                sel_stb = m_stb_i[k];
                s_adr_o = m_adr_i[k*AW +: AW];
                s_dat_o = m_dat_i[k*DW +: DW];
                s_sel_o = m_sel_i[k*SW +: SW];
                s_we_o  = m_we_i[k];
                s_cti_o = m_cti_i[k*3 +: 3];
                s_bte_o = m_bte_i[k*2 +: 2];
            end
        end
    end

    assign s_cyc_o   = owned && sel_cyc && !wd_window;
    assign s_stb_o   = owned && sel_cyc && sel_stb && !wd_window;
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i}};
    assign m_err_o   = grant_q & {NUM_MASTERS{s_err_i | fire}};
    assign m_rty_o   = grant_q & {NUM_MASTERS{s_rty_i}};
    assign grant_o   = grant_q;
    assign timeout_o = fire;

    // Arbitration FSM and watchdog next-state.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    state_d = ST_OWNED;
                    grant_d = win;
                    gidx_d  = win_idx;
                end
            end
            ST_OWNED: begin
                if (!sel_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        cnt_d = cnt_q;
        if (!WD_EN || !owned || term || wd_window) begin
            cnt_d = '0;
        end else if (s_stb_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, grant, rotation pointer and watchdog registers.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;
    localparam int N5 = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- 3-master DUT ----------------
    logic          cyc_a [N];
    logic          stb_a [N];
    logic          we_a  [N];
    logic [AW-1:0] adr_a [N];
    logic [DW-1:0] dat_a [N];
    logic [2:0]    cti_a [N];

    logic [N*AW-1:0]   m_adr_i;
    logic [N*DW-1:0]   m_dat_i;
    logic [N*DW/8-1:0] m_sel_i;
    logic [N-1:0]      m_we_i, m_cyc_i, m_stb_i;
    logic [N*3-1:0]    m_cti_i;
    logic [N*2-1:0]    m_bte_i;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o, s_dat_i;
    logic [DW/8-1:0]   s_sel_o;
    logic              s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i, timeout_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;

    always_comb begin
        m_adr_i = '0; m_dat_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0;
        for (int k = 0; k < N; k++) begin
            m_adr_i[k*AW +: AW] = adr_a[k];
            m_dat_i[k*DW +: DW] = dat_a[k];
            m_we_i[k]           = we_a[k];
            m_cyc_i[k]          = cyc_a[k];
            m_stb_i[k]          = stb_a[k];
            m_cti_i[k*3 +: 3]   = cti_a[k];
        end
        m_sel_i = '1;
        m_bte_i = {N{BTE_LINEAR}};
    end

    wb_rr_arbiter #(.NUM_MASTERS(N), .DW(DW), .AW(AW), .TIMEOUT(TO)) u_dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // Slave model: RAM with registered ack (mode 0) or never-ack (mode 1).
    int          slave_mode = 0;
    logic        ack_r;
    logic        ack_force = 1'b0;
    logic [31:0] mem [16];

    assign s_ack_i = ack_r | ack_force;
    assign s_err_i = 1'b0;
    assign s_rty_i = 1'b0;
    assign s_dat_i = mem[s_adr_o[3:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_r <= 1'b0;
        else        ack_r <= (slave_mode == 0) && s_cyc_o && s_stb_o && !ack_r;
    end

    always @(posedge clk) begin
        if (ack_r && s_stb_o && s_we_o) mem[s_adr_o[3:0]] <= s_dat_o;
    end

    // ---------------- 5-master DUT ----------------
    logic [N5*AW-1:0]   m5_adr_i = '0;
    logic [N5*DW-1:0]   m5_dat_i = '0;
    logic [N5*DW/8-1:0] m5_sel_i = '1;
    logic [N5-1:0]      m5_we_i = '0, m5_cyc_i = '0, m5_stb_i = '0;
    logic [N5*3-1:0]    m5_cti_i = '0;
    logic [N5*2-1:0]    m5_bte_i = '0;
    logic [DW-1:0]      m5_dat_o;
    logic [N5-1:0]      m5_ack_o, m5_err_o, m5_rty_o, grant5_o;
    logic [AW-1:0]      s5_adr_o;
    logic [DW-1:0]      s5_dat_o;
    logic [DW/8-1:0]    s5_sel_o;
    logic               s5_we_o, s5_cyc_o, s5_stb_o, timeout5_o;
    logic [2:0]         s5_cti_o;
    logic [1:0]         s5_bte_o;
    logic               ack5_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack5_r <= 1'b0;
        else        ack5_r <= s5_cyc_o && s5_stb_o && !ack5_r;
    end

    wb_rr_arbiter #(.NUM_MASTERS(N5), .DW(DW), .AW(AW)) u_dut5 (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .m_adr_i(m5_adr_i), .m_dat_i(m5_dat_i), .m_sel_i(m5_sel_i), .m_we_i(m5_we_i),
        .m_cyc_i(m5_cyc_i), .m_stb_i(m5_stb_i), .m_cti_i(m5_cti_i), .m_bte_i(m5_bte_i),
        .m_dat_o(m5_dat_o), .m_ack_o(m5_ack_o), .m_err_o(m5_err_o), .m_rty_o(m5_rty_o),
        .s_adr_o(s5_adr_o), .s_dat_o(s5_dat_o), .s_sel_o(s5_sel_o), .s_we_o(s5_we_o),
        .s_cyc_o(s5_cyc_o), .s_stb_o(s5_stb_o), .s_cti_o(s5_cti_o), .s_bte_o(s5_bte_o),
        .s_dat_i(32'hDEADBEEF), .s_ack_i(ack5_r), .s_err_i(1'b0), .s_rty_i(1'b0),
        .grant_o(grant5_o), .timeout_o(timeout5_o)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int k, input int b);
        return 32'hC0DE_0000 | (32'(k) << 8) | 32'(b);
    endfunction

    // Grant scoreboard: expected owners are queued as stimulus is issued
    // and popped whenever a new owner appears on grant_o.
    logic [N-1:0] exp_grant_q [$];
    logic [N-1:0] grant_prev = '0;

    always @(negedge clk) begin
        if (grant_o != grant_prev && grant_o != '0) begin
            if (grant_prev != '0) check("dead_cycle", {29'd0, grant_prev}, 32'd0);
            if (exp_grant_q.size() == 0) begin
                check("unexpected_grant", {29'd0, grant_o}, 32'd0);
            end else begin
                check("grant_order", {29'd0, grant_o}, {29'd0, exp_grant_q.pop_front()});
            end
        end
        if (|(m_ack_o | m_err_o))
            check("term_to_owner_only", {29'd0, (m_ack_o | m_err_o) & ~grant_o}, 32'd0);
        grant_prev = grant_o;
    end

    task automatic clear_masters();
        for (int k = 0; k < N; k++) begin
            cyc_a[k] = 1'b0; stb_a[k] = 1'b0; we_a[k] = 1'b0;
            adr_a[k] = '0;   dat_a[k] = '0;   cti_a[k] = CTI_CLASSIC;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_masters();
        m5_cyc_i = '0;
        m5_stb_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Master k: nb write beats from address base, classic or incrementing burst.
    task automatic do_master(input int k, input int nb, input int base, input bit burst);
        bit got;
        cyc_a[k] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            adr_a[k] = 32'(base + b);
            dat_a[k] = data_of(k, b);
            we_a[k]  = 1'b1;
            stb_a[k] = 1'b1;
            cti_a[k] = burst ? ((b == nb - 1) ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
            got = 1'b0;
            for (int t = 0; t < 300 && !got; t++) begin
                @(negedge clk);
                if (m_ack_o[k]) got = 1'b1;
            end
            if (!got) check($sformatf("ack_wait_m%0d", k), 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
        stb_a[k] = 1'b0;
        cyc_a[k] = 1'b0;
        we_a[k]  = 1'b0;
        cti_a[k] = CTI_CLASSIC;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stalled;
        bit fired;
        bit got;

        // Rotation table: last_grant carries from row to row (starts at 2).
        tbl[0] = '{req: 3'b111, exp: 3'b001};
        tbl[1] = '{req: 3'b111, exp: 3'b010};
        tbl[2] = '{req: 3'b101, exp: 3'b100};
        tbl[3] = '{req: 3'b011, exp: 3'b001};
        tbl[4] = '{req: 3'b001, exp: 3'b001};
        tbl[5] = '{req: 3'b100, exp: 3'b100};
        tbl[6] = '{req: 3'b010, exp: 3'b010};
        tbl[7] = '{req: 3'b001, exp: 3'b001};
        tbl[8] = '{req: 3'b110, exp: 3'b010};

        for (int a = 0; a < 16; a++) mem[a] = '0;
        clear_masters();
        #2;
        check("rst_grant", {29'd0, grant_o}, 32'd0);
        check("rst_scyc", {31'd0, s_cyc_o}, 32'd0);
        check("rst_sstb", {31'd0, s_stb_o}, 32'd0);
        check("rst_timeout", {31'd0, timeout_o}, 32'd0);
        do_reset();
        check("rst_term", {23'd0, m_ack_o, m_err_o, m_rty_o}, 32'd0);

        // Table-driven rotation
        for (int i = 0; i < 9; i++) begin
            exp_grant_q.push_back(tbl[i].exp);
            for (int k = 0; k < N; k++) cyc_a[k] = tbl[i].req[k];
            @(posedge clk); #1;
            check($sformatf("tbl%0d_grant", i), {29'd0, grant_o}, {29'd0, tbl[i].exp});
            check($sformatf("tbl%0d_scyc", i), {31'd0, s_cyc_o}, 32'd1);
            for (int k = 0; k < N; k++) cyc_a[k] = 1'b0;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_idle", i), {29'd0, grant_o}, 32'd0);
        end

        // Three masters, four classic writes each
        do_reset();
        exp_grant_q.push_back(3'b001);
        exp_grant_q.push_back(3'b010);
        exp_grant_q.push_back(3'b100);
        fork
            do_master(0, 4, 0, 1'b0);
            do_master(1, 4, 4, 1'b0);
            do_master(2, 4, 8, 1'b0);
        join
        for (int a = 0; a < 12; a++)
            check($sformatf("ram%0d", a), mem[a], data_of(a / 4, a % 4));

        // Master 1 burst is not split by master 0's request
        do_reset();
        exp_grant_q.push_back(3'b010);
        exp_grant_q.push_back(3'b001);
        fork
            do_master(1, 8, 0, 1'b1);
            begin
                repeat (2) @(posedge clk);
                #1;
                do_master(0, 1, 15, 1'b0);
            end
        join
        for (int a = 0; a < 8; a++)
            check($sformatf("burst%0d", a), mem[a], data_of(1, a));
        check("burst_m0", mem[15], data_of(0, 0));

        // Watchdog fires after TO stalled cycles
        do_reset();
        slave_mode = 1;
        exp_grant_q.push_back(3'b001);
        cyc_a[0] = 1'b1; stb_a[0] = 1'b1; adr_a[0] = 32'd3;
        stalled = 0; fired = 1'b0;
        for (int t = 0; t < 60 && !fired; t++) begin
            @(negedge clk);
            if (timeout_o) fired = 1'b1;
            else if (s_stb_o) stalled++;
        end
        check("wd_fired", {31'd0, fired}, 32'd1);
        check("wd_stalled", stalled, TO);
        check("wd_err", {29'd0, m_err_o}, 32'd1);
        check("wd_stb_low", {31'd0, s_stb_o}, 32'd0);
        check("wd_cyc_low", {31'd0, s_cyc_o}, 32'd0);
        check("wd_grant_kept", {29'd0, grant_o}, 32'd1);
        @(negedge clk);
        check("wd_err_pulse", {29'd0, m_err_o}, 32'd0);
        check("wd_to_pulse", {31'd0, timeout_o}, 32'd0);
        check("wd_stb_back", {31'd0, s_stb_o}, 32'd1);
        @(posedge clk); #1;
        clear_masters();

        // Termination on the cycle the count reaches TO wins over the watchdog
        do_reset();
        exp_grant_q.push_back(3'b001);
        cyc_a[0] = 1'b1; stb_a[0] = 1'b1;
        stalled = 0;
        for (int t = 0; t < 60 && stalled < TO; t++) begin
            @(negedge clk);
            if (s_stb_o) stalled++;
            if (timeout_o) check("race_early_fire", 32'd1, 32'd0);
        end
        check("race_stalled", stalled, TO);
        @(posedge clk); #1;
        ack_force = 1'b1;
        @(negedge clk);
        check("race_ack", {29'd0, m_ack_o}, 32'd1);
        check("race_no_err", {29'd0, m_err_o}, 32'd0);
        check("race_no_to", {31'd0, timeout_o}, 32'd0);
        @(posedge clk); #1;
        ack_force = 1'b0;
        @(negedge clk);
        check("race_cnt_clr_to", {31'd0, timeout_o}, 32'd0);
        check("race_cnt_clr_stb", {31'd0, s_stb_o}, 32'd1);
        @(posedge clk); #1;
        clear_masters();
        slave_mode = 0;

        // Asynchronous reset in the middle of a master 2 burst
        do_reset();
        exp_grant_q.push_back(3'b100);
        exp_grant_q.push_back(3'b001);
        cyc_a[2] = 1'b1; stb_a[2] = 1'b1; we_a[2] = 1'b1;
        adr_a[2] = 32'd12; dat_a[2] = 32'h5555_AAAA; cti_a[2] = CTI_INCR;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (m_ack_o[2]) got = 1'b1;
        end
        check("rstmid_ack_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rstmid_grant", {29'd0, grant_o}, 32'd0);
        check("rstmid_scyc", {31'd0, s_cyc_o}, 32'd0);
        check("rstmid_sstb", {31'd0, s_stb_o}, 32'd0);
        clear_masters();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc_a[0] = 1'b1; cyc_a[2] = 1'b1;
        @(posedge clk); #1;
        check("rstmid_m0_wins", {29'd0, grant_o}, 32'd1);
        clear_masters();
        @(posedge clk); #1;

        // Five masters, only master 4 reads after reset
        do_reset();
        m5_cyc_i = 5'b10000; m5_stb_i = 5'b10000;
        @(posedge clk); #1;
        check("m5_grant", {27'd0, grant5_o}, 32'h10);
        check("m5_scyc", {31'd0, s5_cyc_o}, 32'd1);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (m5_ack_o[4]) got = 1'b1;
        end
        check("m5_ack_seen", {31'd0, got}, 32'd1);
        check("m5_ack", {27'd0, m5_ack_o}, 32'h10);
        check("m5_dat", m5_dat_o, 32'hDEADBEEF);
        @(posedge clk); #1;
        m5_cyc_i = '0; m5_stb_i = '0;
        repeat (2) @(posedge clk);

        check("grant_queue_empty", exp_grant_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
